// File: rtl/sha256_pkg.sv
// Shared constants, state encoding and word helpers for the SHA-256 digest path.
package sha256_pkg;

    localparam int SHA_WORD_W    = 32;
    localparam int SHA_NUM_WORDS = 8;

    // SHA-256 initial hash values H0..H7, packed with H0 in the top word.
    localparam logic [255:0] SHA_IV = {
        32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
        32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19
    };

    // Reader FSM: IDLE waits for a digest, STREAM presents the snapshot word by word.
    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_STREAM = 1'b1
    } rd_state_e;

    // Reverse the byte order of one 32-bit word (big-endian <-> little-endian view).
    function automatic logic [31:0] byte_swap32(input logic [31:0] w);
        return {w[7:0], w[15:8], w[23:16], w[31:24]};
    endfunction

endpackage

// File: rtl/lz_check.sv
// Combinational difficulty check: true when the top ZERO_BITS bits of i_data are all zero.
// ZERO_BITS = 0 always hits; ZERO_BITS = DATA_W hits only on an all-zero word.
module lz_check #(
    parameter int DATA_W    = 256,
    parameter int ZERO_BITS = 32
) (
    input  logic [DATA_W-1:0] i_data,
    output logic              o_hit
);

    // Mask covering the ZERO_BITS most significant bits. A shift by DATA_W or more
    // yields all zeros, so the 0 and DATA_W edge cases fall out without special paths.
    localparam logic [DATA_W-1:0] ZERO_MASK = ~({DATA_W{1'b1}} >> ZERO_BITS);

    logic [DATA_W-1:0] w_masked;

    // Keep only the bits that must be zero and test that none of them is set.
    always_comb begin
        w_masked = i_data & ZERO_MASK;
        o_hit    = ~(|w_masked);
    end

endmodule

// File: rtl/sha_digest_reader.sv
// Snapshots a finished H0..H7 digest and streams it out one word per ready/valid
// handshake, with a registered leading-zero difficulty flag, a capture counter and
// a sticky overrun flag for digests that arrive while a stream is still draining.
module sha_digest_reader
    import sha256_pkg::*;
#(
    parameter int NUM_WORDS = SHA_NUM_WORDS,
    parameter int WORD_W    = SHA_WORD_W,
    parameter int ZERO_BITS = 32,
    parameter bit BYTE_SWAP = 1'b0,
    localparam int IDX_W    = $clog2(NUM_WORDS),
    localparam int DIG_W    = NUM_WORDS * WORD_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              digest_done,
    input  logic [DIG_W-1:0]  h_in,
    input  logic              word_ready,
    input  logic              clr_overrun,
    output logic [WORD_W-1:0] word_out,
    output logic [IDX_W-1:0]  word_idx,
    output logic              word_valid,
    output logic              word_last,
    output logic              busy,
    output logic              target_hit,
    output logic              overrun,
    output logic [15:0]       digest_count
);

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_WORDS - 1);

    rd_state_e         r_state;
    rd_state_e         w_state_nxt;
    logic [DIG_W-1:0]  r_snap;
    logic [WORD_W-1:0] r_word;
    logic [IDX_W-1:0]  r_idx;
    logic [IDX_W-1:0]  w_idx_nxt;
    logic              r_last;
    logic              r_hit;
    logic              r_overrun;
    logic [15:0]       r_count;
    logic              w_xfer;
    logic              w_final;
    logic              w_capture;
    logic              w_drop;
    logic              w_lz_hit;
    logic [WORD_W-1:0] w_snap_words [NUM_WORDS];

    // Presentation order on word_out; the difficulty check always sees the raw digest.
    function automatic logic [WORD_W-1:0] present(input logic [WORD_W-1:0] w);
        return BYTE_SWAP ? byte_swap32(w) : w;
    endfunction

    // Difficulty compare runs on the incoming digest so the flag can be registered at capture.
    lz_check #(
        .DATA_W    (DIG_W),
        .ZERO_BITS (ZERO_BITS)
    ) u_lz_check (
        .i_data (h_in),
        .o_hit  (w_lz_hit)
    );

    // Split the snapshot into words, word 0 (H0) taken from the top of the vector.
    always_comb begin
        for (int k = 0; k < NUM_WORDS; k++) begin
            w_snap_words[k] = r_snap[DIG_W-1-(k*WORD_W) -: WORD_W];
        end
    end

    // Index of the word presented after a non-final transfer.
    always_comb begin
        w_idx_nxt = r_idx + IDX_W'(1);
    end

    // FSM next-state and handshake decode: transfer, final transfer, capture or drop.
    always_comb begin
        w_state_nxt = r_state;
        w_xfer      = 1'b0;
        w_final     = 1'b0;
        w_capture   = 1'b0;
        w_drop      = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (digest_done) begin
                    w_capture   = 1'b1;
                    w_state_nxt = ST_STREAM;
                end else begin
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_STREAM: begin
                w_xfer  = word_ready;
                w_final = word_ready && (r_idx == LAST_IDX);
                if (w_final && digest_done) begin
                    // New digest lands exactly as the old one finishes: restart with no bubble.
                    w_capture   = 1'b1;
                    w_state_nxt = ST_STREAM;
                end else if (w_final) begin
                    w_state_nxt = ST_IDLE;
                end else begin
                    // Still draining: any digest now has nowhere to go and is dropped.
                    w_drop      = digest_done;
                    w_state_nxt = ST_STREAM;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Snapshot, presented word, index, last flag, difficulty flag and capture counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_snap  <= '0;
            r_word  <= '0;
            r_idx   <= '0;
            r_last  <= 1'b0;
            r_hit   <= 1'b0;
            r_count <= 16'd0;
        end else if (w_capture) begin
            // First word comes from h_in through a register, never combinationally.
            r_snap  <= h_in;
            r_word  <= present(h_in[DIG_W-1 -: WORD_W]);
            r_idx   <= '0;
            r_last  <= (NUM_WORDS == 1);
            r_hit   <= w_lz_hit;
            r_count <= r_count + 16'd1;
        end else if (w_final) begin
            r_word  <= '0;
            r_idx   <= '0;
            r_last  <= 1'b0;
        end else if (w_xfer) begin
            r_word  <= present(w_snap_words[w_idx_nxt]);
            r_idx   <= w_idx_nxt;
            r_last  <= (w_idx_nxt == LAST_IDX);
        end else begin
            // Stall or idle: everything holds so a stalled word stays stable.
            r_snap  <= r_snap;
            r_word  <= r_word;
            r_idx   <= r_idx;
            r_last  <= r_last;
            r_hit   <= r_hit;
            r_count <= r_count;
        end
    end

    // Sticky overrun: a dropped digest sets it and wins over a same-cycle clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_overrun <= 1'b0;
        end else if (w_drop) begin
            r_overrun <= 1'b1;
        end else if (clr_overrun) begin
            r_overrun <= 1'b0;
        end else begin
            r_overrun <= r_overrun;
        end
    end

    assign word_out     = r_word;
    assign word_idx     = r_idx;
    assign word_valid   = (r_state == ST_STREAM);
    assign word_last    = r_last;
    assign busy         = (r_state == ST_STREAM);
    assign target_hit   = r_hit;
    assign overrun      = r_overrun;
    assign digest_count = r_count;

endmodule

// File: tb/tb_sha_digest_reader.sv
// Bench for sha_digest_reader: three instances (ZERO_BITS 32/0/256, one byte-swapped)
// share the stimulus; a queue-free behavioural model tracks what each must show.
module tb_sha_digest_reader;
    import sha256_pkg::*;

    logic         clk = 1'b0;
    logic         rst_n = 1'b1;
    logic         digest_done = 1'b0;
    logic [255:0] h_in = 256'h0;
    logic         word_ready = 1'b0;
    logic         clr_overrun = 1'b0;

    logic [31:0] a_word, s_word, z_word;
    logic [2:0]  a_idx, s_idx, z_idx;
    logic        a_valid, s_valid, z_valid, a_last, s_last, z_last;
    logic        a_busy, s_busy, z_busy, a_hit, s_hit, z_hit, a_over, s_over, z_over;
    logic [15:0] a_cnt, s_cnt, z_cnt;

    int n_checks = 0;
    int n_fail   = 0;

    localparam logic [255:0] ABC =
        256'hba7816bf8f01cfea414140de5dae2223b00361a396177a9cb410ff61f20015ad;
    logic [31:0] abc_w [8] = '{32'hba7816bf, 32'h8f01cfea, 32'h414140de, 32'h5dae2223,
                               32'hb00361a3, 32'h96177a9c, 32'hb410ff61, 32'hf20015ad};

    sha_digest_reader #(.ZERO_BITS(32), .BYTE_SWAP(1'b0)) dut_a (
        .clk(clk), .rst_n(rst_n), .digest_done(digest_done), .h_in(h_in),
        .word_ready(word_ready), .clr_overrun(clr_overrun), .word_out(a_word),
        .word_idx(a_idx), .word_valid(a_valid), .word_last(a_last), .busy(a_busy),
        .target_hit(a_hit), .overrun(a_over), .digest_count(a_cnt));

    sha_digest_reader #(.ZERO_BITS(0), .BYTE_SWAP(1'b1)) dut_s (
        .clk(clk), .rst_n(rst_n), .digest_done(digest_done), .h_in(h_in),
        .word_ready(word_ready), .clr_overrun(clr_overrun), .word_out(s_word),
        .word_idx(s_idx), .word_valid(s_valid), .word_last(s_last), .busy(s_busy),
        .target_hit(s_hit), .overrun(s_over), .digest_count(s_cnt));

    sha_digest_reader #(.ZERO_BITS(256), .BYTE_SWAP(1'b0)) dut_z (
        .clk(clk), .rst_n(rst_n), .digest_done(digest_done), .h_in(h_in),
        .word_ready(word_ready), .clr_overrun(clr_overrun), .word_out(z_word),
        .word_idx(z_idx), .word_valid(z_valid), .word_last(z_last), .busy(z_busy),
        .target_hit(z_hit), .overrun(z_over), .digest_count(z_cnt));

    always #5 clk = ~clk;

    // ---------------- behavioural model ----------------
    logic [31:0] m_words [8];
    bit          m_busy = 1'b0;
    int          m_pos = 0;
    logic [15:0] m_count = 16'd0;
    bit          m_over = 1'b0;
    bit          m_hit [3] = '{1'b0, 1'b0, 1'b0};
    int          zb [3] = '{32, 0, 256};

    function automatic int clz(input logic [255:0] d);
        for (int b = 255; b >= 0; b--) begin
            if (d[b]) return 255 - b;
        end
        return 256;
    endfunction

    function automatic logic [31:0] swap_bytes(input logic [31:0] w);
        return {<<8{w}};
    endfunction

    task automatic model_reset();
        m_busy = 1'b0; m_pos = 0; m_count = 16'd0; m_over = 1'b0;
        for (int i = 0; i < 3; i++) m_hit[i] = 1'b0;
        for (int k = 0; k < 8; k++) m_words[k] = 32'h0;
    endtask

    task automatic model_step();
        bit taken;
        taken = 1'b0;
        if (m_busy && word_ready) begin
            m_pos++;
            if (m_pos == 8) begin
                m_busy = 1'b0;
                m_pos  = 0;
            end
        end
        if (digest_done && !m_busy) begin
            for (int k = 0; k < 8; k++) m_words[k] = h_in[255-32*k -: 32];
            for (int i = 0; i < 3; i++) m_hit[i] = (clz(h_in) >= zb[i]);
            m_busy  = 1'b1;
            m_pos   = 0;
            m_count = m_count + 16'd1;
            taken   = 1'b1;
        end
        if (digest_done && !taken) m_over = 1'b1;
        else if (clr_overrun) m_over = 1'b0;
    endtask

    initial begin
        model_reset();
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) model_reset();
            else model_step();
        end
    end

    // ---------------- checking ----------------
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic cmp_inst(input string tag, input int k, input logic v, input logic [2:0] idx,
                            input logic [31:0] w, input logic l, input logic b, input logic hit,
                            input logic ov, input logic [15:0] cnt);
        logic [31:0] ew;
        chk({tag, "valid"}, 32'(v), 32'(m_busy));
        chk({tag, "busy"}, 32'(b), 32'(m_busy));
        chk({tag, "idx"}, 32'(idx), 32'(m_pos));
        chk({tag, "last"}, 32'(l), 32'(m_busy && m_pos == 7));
        chk({tag, "hit"}, 32'(hit), 32'(m_hit[k]));
        chk({tag, "overrun"}, 32'(ov), 32'(m_over));
        chk({tag, "count"}, 32'(cnt), 32'(m_count));
        if (m_busy) begin
            ew = (k == 1) ? swap_bytes(m_words[m_pos]) : m_words[m_pos];
            chk({tag, "word"}, w, ew);
        end
    endtask

    initial begin
        forever begin
            @(posedge clk);
            #3;
            cmp_inst("a.", 0, a_valid, a_idx, a_word, a_last, a_busy, a_hit, a_over, a_cnt);
            cmp_inst("s.", 1, s_valid, s_idx, s_word, s_last, s_busy, s_hit, s_over, s_cnt);
            cmp_inst("z.", 2, z_valid, z_idx, z_word, z_last, z_busy, z_hit, z_over, z_cnt);
        end
    end

    initial begin
        #50000;
        $display("FAIL watchdog: simulation did not complete, %0d failures so far", n_fail);
        $fatal(1, "watchdog");
    end

    // ---------------- stimulus helpers ----------------
    task automatic pulse(input logic [255:0] d);
        digest_done = 1'b1;
        h_in        = d;
        @(negedge clk);
        digest_done = 1'b0;
    endtask

    task automatic drain();
        word_ready = 1'b1;
        for (int c = 0; c < 20; c++) begin
            if (!a_busy) break;
            @(negedge clk);
        end
        chk("drain_idle", 32'(a_busy), 32'h0);
    endtask

    task automatic wait_idx(input int t);
        for (int c = 0; c < 20; c++) begin
            if (a_valid && 32'(a_idx) == t) break;
            @(negedge clk);
        end
        chk("wait_idx", {28'h0, a_valid, a_idx}, 32'(8 + t));
    endtask

    // ---------------- directed tests ----------------
    initial begin
        int exp_i;
        int xfers;
        #1 rst_n = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("rst_valid", 32'(a_valid), 32'h0);
        chk("rst_word", a_word, 32'h0);
        chk("rst_count", 32'(a_cnt), 32'h0);
        chk("rst_overrun", 32'(a_over), 32'h0);
        rst_n = 1'b1;
        @(negedge clk);

        // 1: "abc" digest, always ready
        word_ready = 1'b1;
        pulse(ABC);
        chk("t1_first_valid", 32'(a_valid), 32'h1);
        chk("t1_first_word", a_word, 32'hba7816bf);
        chk("t1_count", 32'(a_cnt), 32'h1);
        chk("t1_hit32", 32'(a_hit), 32'h0);
        chk("t1_hit0", 32'(s_hit), 32'h1);
        chk("t1_hit256", 32'(z_hit), 32'h0);
        chk("t1_swap", s_word, 32'hbf1678ba);
        for (int i = 0; i < 8; i++) begin
            chk("t1_word", a_word, abc_w[i]);
            chk("t1_idx", 32'(a_idx), 32'(i));
            chk("t1_last", 32'(a_last), 32'(i == 7));
            @(negedge clk);
        end
        chk("t1_done_valid", 32'(a_valid), 32'h0);
        chk("t1_done_last_word", abc_w[7], 32'hf20015ad);

        // 2: stalls with ready pattern 1,0,0,1
        word_ready = 1'b0;
        pulse(ABC);
        exp_i = 0;
        xfers = 0;
        for (int c = 0; c < 40 && a_busy; c++) begin
            chk("t2_hold_word", a_word, abc_w[exp_i]);
            chk("t2_hold_idx", 32'(a_idx), 32'(exp_i));
            word_ready = ((c % 4) == 0) || ((c % 4) == 3);
            @(negedge clk);
            if (word_ready) begin
                xfers++;
                exp_i++;
            end
        end
        chk("t2_xfers", 32'(xfers), 32'd8);
        chk("t2_busy", 32'(a_busy), 32'h0);

        // 3: second digest while stalled is dropped
        word_ready = 1'b0;
        pulse(ABC);
        @(negedge clk);
        @(negedge clk);
        pulse(SHA_IV);
        chk("t3_overrun", 32'(a_over), 32'h1);
        chk("t3_snapshot", a_word, 32'hba7816bf);
        chk("t3_count", 32'(a_cnt), 32'd3);
        digest_done = 1'b1;
        clr_overrun = 1'b1;
        @(negedge clk);
        digest_done = 1'b0;
        clr_overrun = 1'b0;
        chk("t3_set_wins", 32'(a_over), 32'h1);
        clr_overrun = 1'b1;
        @(negedge clk);
        clr_overrun = 1'b0;
        chk("t3_cleared", 32'(a_over), 32'h0);

        // 4: back-to-back capture on the final transfer
        word_ready = 1'b1;
        wait_idx(7);
        pulse(SHA_IV);
        chk("t4_valid", 32'(a_valid), 32'h1);
        chk("t4_idx", 32'(a_idx), 32'h0);
        chk("t4_word", a_word, 32'h6a09e667);
        chk("t4_count", 32'(a_cnt), 32'd4);
        chk("t4_swap", s_word, 32'h67e6096a);
        drain();

        // 5: difficulty boundaries and byte swap
        pulse({32'h0, SHA_IV[223:0]});
        chk("t5_hit32_zero", 32'(a_hit), 32'h1);
        chk("t5_hit256_nz", 32'(z_hit), 32'h0);
        drain();
        pulse({32'h00000001, 224'h0});
        chk("t5_hit32_one", 32'(a_hit), 32'h0);
        chk("t5_hit0_one", 32'(s_hit), 32'h1);
        drain();
        pulse(256'h0);
        chk("t5_hit256_zero", 32'(z_hit), 32'h1);
        drain();
        pulse({32'h11223344, 224'h0});
        chk("t5_swap", s_word, 32'h44332211);
        chk("t5_noswap", a_word, 32'h11223344);
        drain();

        // 6: reset in the middle of a stream
        pulse(ABC);
        wait_idx(4);
        rst_n = 1'b0;
        #1;
        chk("t6_valid", 32'(a_valid), 32'h0);
        chk("t6_idx", 32'(a_idx), 32'h0);
        chk("t6_word", a_word, 32'h0);
        chk("t6_busy", 32'(a_busy), 32'h0);
        chk("t6_count", 32'(a_cnt), 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        chk("t6_idle", 32'(a_valid), 32'h0);
        pulse(SHA_IV);
        chk("t6_restart_idx", 32'(a_idx), 32'h0);
        chk("t6_restart_word", a_word, 32'h6a09e667);
        chk("t6_restart_count", 32'(a_cnt), 32'h1);
        drain();

        @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
